// File: rtl/button_event_decoder_if.sv
// Event bundle between the button decoder and its consumer.
// The consumer drives the debounced level; the decoder returns the events.
interface button_event_decoder_if;
   logic       db;
   logic       press_tick;
   logic       release_tick;
   logic       short_tick;
   logic       long_tick;
   logic       repeat_tick;
   logic       held;
   logic [7:0] event_count;

   modport master (
      output db,
      input  press_tick, release_tick, short_tick, long_tick, repeat_tick, held, event_count
   );

   modport slave (
      input  db,
      output press_tick, release_tick, short_tick, long_tick, repeat_tick, held, event_count
   );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press, release, short,
// long and auto-repeat events, plus a held flag and a wrapping event counter.
module button_event_decoder #(
   parameter int CNT_W         = 26,
   parameter int LONG_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input logic                   clk,
   input logic                   reset,
   button_event_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HOLD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic             db_prev;
   logic             rise;

   // db_prev resets high so a level already high through reset is not a press
   assign rise = bus.db & ~db_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         timer            <= '0;
         db_prev          <= 1'b1;
         bus.press_tick   <= 1'b0;
         bus.release_tick <= 1'b0;
         bus.short_tick   <= 1'b0;
         bus.long_tick    <= 1'b0;
         bus.repeat_tick  <= 1'b0;
         bus.held         <= 1'b0;
         bus.event_count  <= 8'd0;
      end else begin
         db_prev          <= bus.db;
         bus.press_tick   <= 1'b0;
         bus.release_tick <= 1'b0;
         bus.short_tick   <= 1'b0;
         bus.long_tick    <= 1'b0;
         bus.repeat_tick  <= 1'b0;
         case (state)
            IDLE: begin
               bus.held <= 1'b0;
               if (rise) begin
                  state           <= PRESSED;
                  timer           <= '0;
                  bus.press_tick  <= 1'b1;
                  bus.event_count <= bus.event_count + 8'd1;
               end
            end
            // Release is tested first so it wins over a coincident timeout
            PRESSED: begin
               if (!bus.db) begin
                  state            <= IDLE;
                  bus.release_tick <= 1'b1;
                  bus.short_tick   <= 1'b1;
               end else if (timer == LONG_LAST) begin
                  state         <= LONG_HOLD;
                  timer         <= '0;
                  bus.long_tick <= 1'b1;
                  bus.held      <= 1'b1;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            LONG_HOLD: begin
               if (!bus.db) begin
                  state            <= IDLE;
                  bus.release_tick <= 1'b1;
                  bus.held         <= 1'b0;
               end else if (timer == REPEAT_LAST) begin
                  timer           <= '0;
                  bus.repeat_tick <= 1'b1;
                  bus.event_count <= bus.event_count + 8'd1;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               timer    <= '0;
               bus.held <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with short thresholds,
// directed scenarios plus randomized press patterns against a reference model.
module tb_button_event_decoder;

   localparam int LONG_CYCLES   = 8;
   localparam int REPEAT_CYCLES = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   button_event_decoder_if bus_if ();

   button_event_decoder #(
      .CNT_W        (26),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: counts edges since the press and derives every event
   // from that press age with plain arithmetic.
   logic       m_prev, m_active;
   int         m_age;
   logic       m_press, m_release, m_short, m_long, m_repeat, m_held;
   logic [7:0] m_count;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_prev = 1'b1; m_active = 1'b0; m_age = 0;
         m_press = 0; m_release = 0; m_short = 0; m_long = 0; m_repeat = 0; m_held = 0;
         m_count = 8'd0;
      end else begin
         m_press = 0; m_release = 0; m_short = 0; m_long = 0; m_repeat = 0;
         if (m_active && !bus_if.db) begin
            m_release = 1;
            m_short   = (m_age < LONG_CYCLES);
            m_held    = 0;
            m_active  = 0;
         end else if (m_active) begin
            m_age    = m_age + 1;
            m_long   = (m_age == LONG_CYCLES);
            m_repeat = (m_age > LONG_CYCLES) && ((m_age - LONG_CYCLES) % REPEAT_CYCLES == 0);
            m_held   = (m_age >= LONG_CYCLES);
            if (m_repeat) m_count = m_count + 8'd1;
         end else if (bus_if.db && !m_prev) begin
            m_active = 1;
            m_age    = 0;
            m_press  = 1;
            m_count  = m_count + 8'd1;
         end
         m_prev = bus_if.db;
      end
   end

   logic [13:0] obs, exp_v;
   assign obs   = {bus_if.press_tick, bus_if.release_tick, bus_if.short_tick, bus_if.long_tick,
                   bus_if.repeat_tick, bus_if.held, bus_if.event_count};
   assign exp_v = {m_press, m_release, m_short, m_long, m_repeat, m_held, m_count};

   task automatic do_reset(input logic level);
      @(negedge clk);
      bus_if.db = level;
      reset = 1'b1;
      #3 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         bus_if.db = 1'b0;
         @(posedge clk); @(negedge clk);
         checks++;
         if (obs !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d: got %h expected 0", i, obs);
         end
      end
   endtask

   task automatic test_short_press();
      logic [3:0] press_seen, short_seen, rel_seen, long_seen;
      do_reset(1'b0);
      press_seen = '0; short_seen = '0; rel_seen = '0; long_seen = '0;
      for (int i = 0; i < 4; i++) begin
         bus_if.db = (i < 3);
         @(posedge clk); @(negedge clk);
         press_seen[i] = bus_if.press_tick;
         short_seen[i] = bus_if.short_tick;
         rel_seen[i]   = bus_if.release_tick;
         long_seen[i]  = bus_if.long_tick;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL short_model cycle %0d: got %h expected %h", i, obs, exp_v);
         end
      end
      checks++;
      if ({press_seen, short_seen, rel_seen, long_seen} !== {4'b0001, 4'b1000, 4'b1000, 4'b0000}) begin
         errors++;
         $display("[TB] FAIL short_ticks: got %b expected %b",
                  {press_seen, short_seen, rel_seen, long_seen}, {4'b0001, 4'b1000, 4'b1000, 4'b0000});
      end
      checks++;
      if (bus_if.event_count !== 8'd1) begin
         errors++;
         $display("[TB] FAIL short_count: got %0d expected 1", bus_if.event_count);
      end
   endtask

   task automatic test_long_hold(input int high_len, input string name,
                                 input logic [18:0] exp_long, input logic [18:0] exp_rep,
                                 input logic [18:0] exp_rel, input logic [18:0] exp_held,
                                 input logic [7:0] exp_count);
      logic [18:0] long_seen, rep_seen, rel_seen, held_seen, short_seen;
      do_reset(1'b0);
      long_seen = '0; rep_seen = '0; rel_seen = '0; held_seen = '0; short_seen = '0;
      for (int i = 0; i <= high_len; i++) begin
         bus_if.db = (i < high_len);
         @(posedge clk); @(negedge clk);
         long_seen[i]  = bus_if.long_tick;
         rep_seen[i]   = bus_if.repeat_tick;
         rel_seen[i]   = bus_if.release_tick;
         held_seen[i]  = bus_if.held;
         short_seen[i] = bus_if.short_tick;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s_model cycle %0d: got %h expected %h", name, i, obs, exp_v);
         end
      end
      checks++;
      if ({long_seen, rep_seen, rel_seen, held_seen, short_seen} !==
          {exp_long, exp_rep, exp_rel, exp_held, 19'd0}) begin
         errors++;
         $display("[TB] FAIL %s_ticks: got long=%b rep=%b rel=%b held=%b short=%b", name,
                  long_seen, rep_seen, rel_seen, held_seen, short_seen);
      end
      checks++;
      if (bus_if.event_count !== exp_count) begin
         errors++;
         $display("[TB] FAIL %s_count: got %0d expected %0d", name, bus_if.event_count, exp_count);
      end
   endtask

   task automatic test_mid_reset();
      do_reset(1'b0);
      for (int i = 0; i < 11; i++) begin
         bus_if.db = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (bus_if.held !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_held_before: got %b expected 1", bus_if.held);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 14'd0) begin
         errors++;
         $display("[TB] FAIL midreset_async_clear: got %h expected 0", obs);
      end
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (bus_if.press_tick !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL midreset_no_press cycle %0d: got %h expected %h", i, obs, exp_v);
         end
      end
      bus_if.db = 1'b0;
      @(posedge clk); @(negedge clk);
      bus_if.db = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus_if.press_tick !== 1'b1 || bus_if.event_count !== 8'd1) begin
         errors++;
         $display("[TB] FAIL midreset_repress: got press=%b count=%0d expected press=1 count=1",
                  bus_if.press_tick, bus_if.event_count);
      end
   endtask

   task automatic test_count_wrap();
      do_reset(1'b0);
      for (int n = 1; n <= 257; n++) begin
         bus_if.db = 1'b1;
         @(posedge clk); @(negedge clk);
         bus_if.db = 1'b0;
         @(posedge clk); @(negedge clk);
         if (n == 256 || n == 257) begin
            checks++;
            if (bus_if.event_count !== 8'(n - 256)) begin
               errors++;
               $display("[TB] FAIL count_wrap after %0d presses: got %0d expected %0d",
                        n, bus_if.event_count, n - 256);
            end
         end
      end
   endtask

   task automatic test_random();
      logic level;
      int   run_len;
      do_reset(1'b0);
      level = 1'b0;
      for (int seg = 0; seg < 60; seg++) begin
         level = ~level;
         run_len = (($urandom_range(0, 3) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 6));
         if ($urandom_range(0, 19) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
         for (int i = 0; i < run_len; i++) begin
            bus_if.db = level;
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("[TB] FAIL random seg %0d cycle %0d: got %h expected %h", seg, i, obs, exp_v);
            end
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus_if.db = 1'b0;
      test_reset();
      test_short_press();
      test_long_hold(18, "long_hold", 19'(1) << 8, (19'(1) << 12) | (19'(1) << 16),
                     19'(1) << 18, 19'h3FF00, 8'd3);
      test_long_hold(12, "release_vs_repeat", 19'(1) << 8, 19'd0,
                     19'(1) << 12, 19'h00F00, 8'd1);
      test_mid_reset();
      test_count_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
